// File: rtl/ps2_scan_digits.sv
// PS/2 keyboard receiver + key tracker driving scan-code and BCD press-count digits; optional odd-parity check via PS2_PARITY_CHECK_EN.
// Latency: byte strobe one cycle after the stop-bit falling edge is seen, outputs one cycle later; no backpressure (PS/2 cannot be stalled).
module ps2_scan_digits #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] code_hi,
    output logic [3:0] code_lo,
    output logic [3:0] cnt_hi,
    output logic [3:0] cnt_lo,
    output logic       key_active,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HELD     = 2'd1;
    localparam logic [1:0] BRK_IDLE = 2'd2;
    localparam logic [1:0] BRK_HELD = 2'd3;

    logic [2:0]    clk_sync;
    logic [2:0]    dat_sync;
    logic          fall;
    logic          dat_bit;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] to_cnt;
    logic          frame_ok;
    logic          byte_vld;
    logic [7:0]    byte_dat;

    logic [1:0]    state;
    logic [7:0]    code;
    logic [3:0]    cnt_t;
    logic [3:0]    cnt_u;

    // Index 0 is the newest sample; the edge is judged on the two oldest.
    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign dat_bit = dat_sync[1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 3'b000;
            dat_sync <= 3'b000;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    // shreg holds start in [0], data LSB-first in [8:1], parity in [9]; stop is the live bit.
    always_comb begin
        frame_ok = ~shreg[0] & dat_bit;
`ifdef PS2_PARITY_CHECK_EN
        frame_ok = frame_ok & (^shreg[9:1]);
`endif
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt   <= 4'd0;
            shreg     <= 10'd0;
            to_cnt    <= '0;
            byte_vld  <= 1'b0;
            byte_dat  <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        byte_vld <= 1'b1;
                        byte_dat <= shreg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {dat_bit, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is dropped silently.
                if (to_cnt == TO_LAST) begin
                    bit_cnt <= 4'd0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            code  <= 8'd0;
            cnt_t <= 4'd0;
            cnt_u <= 4'd0;
        end else if (byte_vld && byte_dat != 8'hE0) begin
            case (state)
                IDLE: begin
                    if (byte_dat == 8'hF0) begin
                        state <= BRK_IDLE;
                    end else begin
                        state <= HELD;
                        code  <= byte_dat;
                        if (cnt_u == 4'd9) begin
                            cnt_u <= 4'd0;
                            cnt_t <= (cnt_t == 4'd9) ? 4'd0 : cnt_t + 4'd1;
                        end else begin
                            cnt_u <= cnt_u + 4'd1;
                        end
                    end
                end
                HELD: begin
                    if (byte_dat == code) begin
                        state <= HELD;
                    end else if (byte_dat == 8'hF0) begin
                        state <= BRK_HELD;
                    end else begin
                        code <= byte_dat;
                        if (cnt_u == 4'd9) begin
                            cnt_u <= 4'd0;
                            cnt_t <= (cnt_t == 4'd9) ? 4'd0 : cnt_t + 4'd1;
                        end else begin
                            cnt_u <= cnt_u + 4'd1;
                        end
                    end
                end
                BRK_HELD: state <= (byte_dat == code) ? IDLE : HELD;
                default:  state <= IDLE;
            endcase
        end
    end

    assign code_hi    = code[7:4];
    assign code_lo    = code[3:0];
    assign cnt_hi     = cnt_t;
    assign cnt_lo     = cnt_u;
    assign key_active = (state == HELD) || (state == BRK_HELD);

endmodule

// File: tb/tb_ps2_scan_digits.sv
// Directed bench for ps2_scan_digits: frame table plus timeout, mid-frame reset and BCD wrap sequences.
module tb_ps2_scan_digits;

    localparam int TO = 64;
    localparam int H  = 4;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] code_hi, code_lo, cnt_hi, cnt_lo;
    logic       key_active, frame_err;

    int pass_cnt = 0;
    int total    = 0;
    int err_cycles = 0;

    ps2_scan_digits #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_hi(code_hi), .code_lo(code_lo), .cnt_hi(cnt_hi), .cnt_lo(cnt_lo),
        .key_active(key_active), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) err_cycles++;

    typedef struct {
        logic [7:0] dat;
        int         kind;   // 0 good, 1 bad parity, 2 bad start, 3 bad stop
        logic [7:0] code;
        logic [7:0] cnt;
        logic       act;
        int         err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = b[i];
            repeat (H) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input int kind);
        logic st, sp, par;
        st  = (kind == 2);
        sp  = (kind != 3);
        par = (kind == 1) ? ^d : ~^d;
        return {sp, par, d, st};
    endfunction

    task automatic send_frame(input logic [7:0] d, input int kind);
        send_bits(mk_frame(d, kind), 11);
        repeat (10) @(posedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] c, input logic [7:0] n, input logic a);
        @(negedge clk);
        chk({tag, ".code"}, {code_hi, code_lo}, c);
        chk({tag, ".cnt"},  {cnt_hi, cnt_lo}, n);
        chk({tag, ".active"}, key_active, a);
    endtask

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        int e0;
        logic [7:0] exp_code, exp_cnt;

        vecs[0]  = '{8'h1C, 0, 8'h1C, 8'h01, 1'b1, 0};
        vecs[1]  = '{8'h1C, 0, 8'h1C, 8'h01, 1'b1, 0};
        vecs[2]  = '{8'h1C, 0, 8'h1C, 8'h01, 1'b1, 0};
        vecs[3]  = '{8'h1C, 0, 8'h1C, 8'h01, 1'b1, 0};
        vecs[4]  = '{8'hF0, 0, 8'h1C, 8'h01, 1'b1, 0};
        vecs[5]  = '{8'h1C, 0, 8'h1C, 8'h01, 1'b0, 0};
        vecs[6]  = '{8'hE0, 0, 8'h1C, 8'h01, 1'b0, 0};
        vecs[7]  = '{8'hF0, 0, 8'h1C, 8'h01, 1'b0, 0};
        vecs[8]  = '{8'h32, 0, 8'h1C, 8'h01, 1'b0, 0};
        vecs[9]  = '{8'h32, 0, 8'h32, 8'h02, 1'b1, 0};
        vecs[10] = '{8'h24, 0, 8'h24, 8'h03, 1'b1, 0};
        vecs[11] = '{8'hF0, 0, 8'h24, 8'h03, 1'b1, 0};
        vecs[12] = '{8'h32, 0, 8'h24, 8'h03, 1'b1, 0};
`ifdef PS2_PARITY_CHECK_EN
        vecs[13] = '{8'h1C, 1, 8'h24, 8'h03, 1'b1, 1};
        vecs[14] = '{8'h55, 3, 8'h24, 8'h03, 1'b1, 1};
        vecs[15] = '{8'h66, 2, 8'h24, 8'h03, 1'b1, 1};
`else
        vecs[13] = '{8'h1C, 1, 8'h1C, 8'h04, 1'b1, 0};
        vecs[14] = '{8'h55, 3, 8'h1C, 8'h04, 1'b1, 1};
        vecs[15] = '{8'h66, 2, 8'h1C, 8'h04, 1'b1, 1};
`endif

        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        chk_out("reset", 8'h00, 8'h00, 1'b0);
        chk("reset.err", frame_err, 1'b0);
        clrn = 1'b1;
        repeat (5) @(posedge clk);

        foreach (vecs[i]) begin
            e0 = err_cycles;
            send_frame(vecs[i].dat, vecs[i].kind);
            chk_out($sformatf("vec%0d", i), vecs[i].code, vecs[i].cnt, vecs[i].act);
            chk($sformatf("vec%0d.err_cycles", i), err_cycles - e0, vecs[i].err);
        end

        // Stalled partial frame must time out silently, then a full 0x32 frame is a new key.
        exp_cnt = vecs[15].cnt + 8'h01;
        e0 = err_cycles;
        send_bits(mk_frame(8'h32, 0), 5);
        repeat (TO + 10) @(posedge clk);
        send_frame(8'h32, 0);
        chk_out("timeout", 8'h32, exp_cnt, 1'b1);
        chk("timeout.err_cycles", err_cycles - e0, 0);

        // Reset after bit 6 of a frame; the next frame must decode cleanly.
        send_bits(mk_frame(8'h5A, 0), 7);
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        chk_out("midreset", 8'h00, 8'h00, 1'b0);
        clrn = 1'b1;
        repeat (5) @(posedge clk);
        e0 = err_cycles;
        send_frame(8'h24, 0);
        chk_out("after_reset", 8'h24, 8'h01, 1'b1);
        chk("after_reset.err_cycles", err_cycles - e0, 0);

        // 100 press/release cycles: count walks 01..99 then wraps to 00.
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        clrn = 1'b1;
        repeat (5) @(posedge clk);
        for (int i = 1; i <= 100; i++) begin
            send_frame(8'h1C, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d.cnt", i), {cnt_hi, cnt_lo}, bcd(i % 100));
            send_frame(8'hF0, 0);
            send_frame(8'h1C, 0);
        end
        exp_code = 8'h1C;
        chk_out("wrap_end", exp_code, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/ps2_scan_digits.md
PS2_SCAN_DIGITS -- requirements
Module: ps2_scan_digits

Interface
REQ-001 The module SHALL take parameter TIMEOUT_CYCLES, default 50000: idle clk cycles mid-frame before the receiver abandons the partial frame.
REQ-002 The module SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port clrn, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock, asynchronous to clk.
REQ-005 The module SHALL have port ps2_data, input, 1 bit: raw PS/2 data.
REQ-006 The module SHALL have ports code_hi and code_lo, output, 4 bits each: high and low nibble of the current key's scan code, for the downstream hex-to-7-segment decoders.
REQ-007 The module SHALL have ports cnt_hi and cnt_lo, output, 4 bits each: BCD tens and units of the key-press count.
REQ-008 The module SHALL have port key_active, output, 1 bit: high while a key is held; display blanking enable.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-cycle pulse per rejected frame.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 3-flop synchronizer; a falling edge is detected in cycle E when the two oldest synchronized ps2_clk samples are 1 then 0.
REQ-011 On each detected falling edge the synchronized ps2_data SHALL be shifted in; a bit counter counts 0..10 (start, 8 data LSB first, parity, stop).
REQ-012 On the edge with counter==10 the frame SHALL be checked (start==0, stop==1, plus parity per REQ-025); the counter returns to 0 regardless of outcome.
REQ-013 A valid frame SHALL assert an internal byte strobe at cycle E+1; the key FSM and all outputs update at E+2.
REQ-014 An invalid frame SHALL pulse frame_err for exactly one cycle at E+1 and deliver no byte.
REQ-015 When the counter is nonzero and no falling edge occurs for TIMEOUT_CYCLES consecutive cycles, the counter SHALL reset to 0 without a byte or frame_err.
REQ-016 Key FSM states SHALL be IDLE, HELD, BRK_IDLE and BRK_HELD; byte 0xE0 is ignored in every state.
REQ-017 In IDLE, byte 0xF0 SHALL go to BRK_IDLE; any other byte latches the code, increments the count and goes to HELD.
REQ-018 In HELD, a byte equal to the latched code (typematic repeat) SHALL change nothing; 0xF0 goes to BRK_HELD; any other byte latches the new code, increments the count and stays in HELD.
REQ-019 In BRK_HELD, a byte equal to the latched code SHALL go to IDLE; any other byte returns to HELD with code and count unchanged.
REQ-020 In BRK_IDLE, any byte SHALL return to IDLE with no output change.
REQ-021 key_active SHALL be 1 exactly in HELD and BRK_HELD; code_hi/code_lo retain the last code in IDLE.
REQ-022 The count SHALL be two-digit BCD, incrementing 09->10 and 99->00 (wrap, no flag).

Reset
REQ-023 While clrn==0, all outputs SHALL be 0, the FSM SHALL be IDLE, and the bit counter, shift register, timeout counter and synchronizers SHALL be cleared, all asynchronously.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame; the first falling edge after release SHALL be treated as a start bit.

Configuration
REQ-025 Macro PS2_PARITY_CHECK_EN, when defined, SHALL additionally require odd parity over the 8 data bits plus the parity bit; a parity failure is handled per REQ-014.
REQ-026 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be ignored, and only start/stop errors raise frame_err.

Verification
REQ-027 Send frame 0x1C (key A) after reset -> code_hi=1, code_lo=C, cnt=01, key_active=1 at E+2.
REQ-028 Send 0x1C three more times, then F0 1C -> cnt stays 01, key_active=0 after the final byte, code stays 1C.
REQ-029 Press/release 100 distinct cycles of 0x1C -> cnt reads 99 then wraps to 00; code stays 1C.
REQ-030 With PS2_PARITY_CHECK_EN defined, send 0x1C with even parity -> frame_err pulses 1 cycle, outputs unchanged; without the macro -> byte accepted.
REQ-031 Send 5 bits, stall ps2_clk for TIMEOUT_CYCLES+1, then a full 0x32 frame -> code=32, cnt increments by 1, no frame_err.
REQ-032 Pull clrn low after bit 6 of a frame, release, then send 0x24 -> cnt=01, code=24.
